// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared constants and types for the MIPS main-control pipeline:
//   - opcode / funct constants
//   - ALU-op encodings (ADD, SUB, R_FORMAT, ORI)
//   - per-stage control bundles (EX carries everything, MEM and WB carry
//     only what they still need)
// Configuration: MAIN_CONTROL_ORI_EN (consumed by main_decoder) enables ori.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FUNCT_JR = 6'd8;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_RFMT = 2'd2,
        ALU_ORI  = 2'd3
    } alu_op_e;

    // Full decoded bundle, held in the ID/EX register. An all-zero value is
    // a bubble.
    typedef struct packed {
        logic       valid;
        alu_op_e    alu_op;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       jr;
        logic [5:0] funct;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] dest;
    } ex_ctrl_t;

    localparam int EX_CTRL_W = $bits(ex_ctrl_t);

    typedef struct packed {
        logic       valid;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] dest;
    } mem_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] dest;
    } wb_ctrl_t;

    // Instructions whose rt field is a source operand (not a destination).
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/main_decoder.sv
// -----------------------------------------------------------------------------
// main_decoder
// Purely combinational opcode/funct decode for the ID stage.
// Ports:
//   id_valid        - instruction present in ID
//   opcode, funct   - instruction fields
//   id_rt, id_rd    - candidate destination registers
//   ctrl            - flattened ex_ctrl_t; all-zero (bubble) when id_valid is
//                     low or the opcode is not recognised
//   illegal         - id_valid with an unrecognised opcode
// Configuration: MAIN_CONTROL_ORI_EN defined -> opcode 13 (ori) is legal;
// otherwise opcode 13 is treated as illegal.
// -----------------------------------------------------------------------------
module main_decoder
    import mips_ctrl_pkg::*;
(
    input  logic                 id_valid,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic [4:0]           id_rt,
    input  logic [4:0]           id_rd,
    output logic [EX_CTRL_W-1:0] ctrl,
    output logic                 illegal
);

    ex_ctrl_t dec_c;
    logic     reg_dst;
    logic     legal;

    always_comb begin
        dec_c   = '0;
        reg_dst = 1'b0;
        legal   = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                dec_c.alu_op    = ALU_RFMT;
                reg_dst         = 1'b1;
                dec_c.reg_write = 1'b1;
                // jr is R-format but writes nothing.
                if (funct == FUNCT_JR) begin
                    dec_c.jr        = 1'b1;
                    dec_c.reg_write = 1'b0;
                end
            end
            OP_LW: begin
                dec_c.alu_op     = ALU_ADD;
                dec_c.alu_src    = 1'b1;
                dec_c.mem_read   = 1'b1;
                dec_c.mem_to_reg = 1'b1;
                dec_c.reg_write  = 1'b1;
            end
            OP_SW: begin
                dec_c.alu_op    = ALU_ADD;
                dec_c.alu_src   = 1'b1;
                dec_c.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_c.alu_op = ALU_SUB;
                dec_c.branch = 1'b1;
            end
            OP_ADDI: begin
                dec_c.alu_op    = ALU_ADD;
                dec_c.alu_src   = 1'b1;
                dec_c.reg_write = 1'b1;
            end
            OP_J: begin
                dec_c.jump = 1'b1;
            end
`ifdef MAIN_CONTROL_ORI_EN
            OP_ORI: begin
                dec_c.alu_op    = ALU_ORI;
                dec_c.alu_src   = 1'b1;
                dec_c.reg_write = 1'b1;
            end
`endif
            default: legal = 1'b0;
        endcase

        dec_c.valid = 1'b1;
        dec_c.funct = funct;
        dec_c.dest  = reg_dst ? id_rd : id_rt;
        // $zero is never written.
        if (dec_c.dest == 5'd0) begin
            dec_c.reg_write = 1'b0;
        end

        if (!id_valid || !legal) begin
            dec_c = '0;
        end
    end

    assign ctrl    = dec_c;
    assign illegal = id_valid && !legal;

endmodule

// File: rtl/main_control_pipe.sv
// -----------------------------------------------------------------------------
// main_control_pipe
// Carries decoded control from ID through EX, MEM and WB, with load-use
// hazard detection and stall/flush handling.
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   id_valid, opcode, funct,
//   id_rs, id_rt, id_rd              - ID-stage instruction
//   stall_in                         - freeze every stage
//   flush                            - squash the ID instruction
//   ex_*                             - EX-stage control
//   mem_valid, mem_read, mem_write   - MEM-stage control
//   wb_*                             - WB-stage control
//   hazard_stall                     - combinational load-use stall
//   illegal_op                       - registered one-cycle illegal pulse
// Configuration: MAIN_CONTROL_ORI_EN enables ori decode (see main_decoder).
// -----------------------------------------------------------------------------
module main_control_pipe
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    input  logic       stall_in,
    input  logic       flush,
    output logic       ex_valid,
    output logic [1:0] ex_alu_op,
    output logic       ex_alu_src,
    output logic       ex_branch,
    output logic       ex_jump,
    output logic       ex_jr,
    output logic [5:0] ex_funct,
    output logic       mem_valid,
    output logic       mem_read,
    output logic       mem_write,
    output logic       wb_valid,
    output logic       wb_reg_write,
    output logic       wb_mem_to_reg,
    output logic [4:0] wb_dest,
    output logic       hazard_stall,
    output logic       illegal_op
);

    logic [EX_CTRL_W-1:0] dec_bits;
    logic                 dec_illegal;
    ex_ctrl_t             dec_ctrl;

    ex_ctrl_t  ex_reg,  ex_next;
    mem_ctrl_t mem_reg, mem_next;
    wb_ctrl_t  wb_reg,  wb_next;
    logic      illegal_op_reg, illegal_op_next;

    main_decoder u_decoder (
        .id_valid (id_valid),
        .opcode   (opcode),
        .funct    (funct),
        .id_rt    (id_rt),
        .id_rd    (id_rd),
        .ctrl     (dec_bits),
        .illegal  (dec_illegal)
    );

    assign dec_ctrl = ex_ctrl_t'(dec_bits);

    // Load in EX whose result the ID instruction needs. rt only counts when
    // the ID instruction actually reads it. Gated by rst_n so it reads 0
    // while reset is held.
    assign hazard_stall = rst_n && id_valid && ex_reg.valid && ex_reg.mem_read
                       && (ex_reg.dest != 5'd0)
                       && ((ex_reg.dest == id_rs)
                           || (reads_rt(opcode) && (ex_reg.dest == id_rt)));

    always_comb begin
        ex_next         = ex_reg;
        mem_next        = mem_reg;
        wb_next         = wb_reg;
        // A freeze clears the pulse so it cannot stretch past one cycle.
        illegal_op_next = 1'b0;
        if (!stall_in) begin
            if (flush || hazard_stall) begin
                ex_next = '0;
            end else begin
                ex_next = dec_ctrl;
            end

            mem_next.valid      = ex_reg.valid;
            mem_next.mem_read   = ex_reg.mem_read;
            mem_next.mem_write  = ex_reg.mem_write;
            mem_next.reg_write  = ex_reg.reg_write;
            mem_next.mem_to_reg = ex_reg.mem_to_reg;
            mem_next.dest       = ex_reg.dest;

            wb_next.valid      = mem_reg.valid;
            wb_next.reg_write  = mem_reg.reg_write;
            wb_next.mem_to_reg = mem_reg.mem_to_reg;
            wb_next.dest       = mem_reg.dest;

            // A flushed or stalled illegal op has not really been issued.
            illegal_op_next = dec_illegal && !flush && !hazard_stall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_reg         <= '0;
            mem_reg        <= '0;
            wb_reg         <= '0;
            illegal_op_reg <= 1'b0;
        end else begin
            ex_reg         <= ex_next;
            mem_reg        <= mem_next;
            wb_reg         <= wb_next;
            illegal_op_reg <= illegal_op_next;
        end
    end

    assign ex_valid      = ex_reg.valid;
    assign ex_alu_op     = ex_reg.alu_op;
    assign ex_alu_src    = ex_reg.alu_src;
    assign ex_branch     = ex_reg.branch;
    assign ex_jump       = ex_reg.jump;
    assign ex_jr         = ex_reg.jr;
    assign ex_funct      = ex_reg.funct;
    assign mem_valid     = mem_reg.valid;
    assign mem_read      = mem_reg.mem_read;
    assign mem_write     = mem_reg.mem_write;
    assign wb_valid      = wb_reg.valid;
    assign wb_reg_write  = wb_reg.reg_write;
    assign wb_mem_to_reg = wb_reg.mem_to_reg;
    assign wb_dest       = wb_reg.dest;
    assign illegal_op    = illegal_op_reg;

endmodule
